// File: rtl/mccpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcodes, datapath mux select codes and the control word carried to the
// datapath. The datapath muxes and the control FSM both import this package.
package mccpu_pkg;

    // FSM state encodings
    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_MADDR = 4'd2;
    localparam logic [3:0] S_MRD   = 4'd3;
    localparam logic [3:0] S_WBL   = 4'd4;
    localparam logic [3:0] S_MWR   = 4'd5;
    localparam logic [3:0] S_EXR   = 4'd6;
    localparam logic [3:0] S_WBR   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;
    localparam logic [3:0] S_EXI   = 4'd10;
    localparam logic [3:0] S_WBI   = 4'd11;
    localparam logic [3:0] S_TRAP  = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU B operand select
    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Datapath control word (the trap flag travels separately because it
    // only exists when the illegal-opcode trap is built in)
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mccpu_ctrl_decode.sv
// Combinational state -> control word decoder for the multi-cycle control FSM.
// Optional macro MCCPU_ILLEGAL_TRAP_EN adds the TRAP state decode and the
// exc_trap_o output.
module mccpu_ctrl_decode
    import mccpu_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic [ST_W-1:0] state_i,
`ifdef MCCPU_ILLEGAL_TRAP_EN
    output logic            exc_trap_o,
`endif
    output ctrl_t           ctrl_o
);

    // Moore decode: every control bit is a function of the state alone
    always_comb begin
        ctrl_o = '0;
`ifdef MCCPU_ILLEGAL_TRAP_EN
        exc_trap_o = 1'b0;
`endif
        case (state_i)
            ST_W'(S_IF): begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = ALUB_FOUR;
            end
            ST_W'(S_ID): begin
                // branch target is precomputed while the opcode decodes
                ctrl_o.alu_src_b = ALUB_IMMSH;
            end
            ST_W'(S_MADDR), ST_W'(S_EXI): begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
            end
            ST_W'(S_MRD): begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_W'(S_MWR): begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_W'(S_WBL): begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_W'(S_EXR): begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_W'(S_WBR): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_W'(S_WBI): begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_W'(S_BR): begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_W'(S_JMP): begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MCCPU_ILLEGAL_TRAP_EN
            ST_W'(S_TRAP): begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_EXC;
                exc_trap_o       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: holds the state register and
// next-state logic; the control word is decoded from state by
// mccpu_ctrl_decode. All controls are held at 0 while reset is high.
// Optional macro MCCPU_ILLEGAL_TRAP_EN: undefined opcodes go to TRAP and the
// ExcTrap port is present; otherwise they fall back to IF as a NOP.
module multicycle_ctrl_fsm
    import mccpu_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] OpCode,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
`ifdef MCCPU_ILLEGAL_TRAP_EN
    output logic            ExcTrap,
`endif
    output logic [ST_W-1:0] State
);

    logic [ST_W-1:0] state_q, state_d;
    ctrl_t           ctrl_raw, ctrl;

    // Next-state: one cycle per state; OpCode is stable from ID onward
    always_comb begin
        state_d = ST_W'(S_IF);
        case (state_q)
            ST_W'(S_IF): state_d = ST_W'(S_ID);
            ST_W'(S_ID): begin
                case (OpCode)
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):    state_d = ST_W'(S_MADDR);
                    OP_W'(OP_RTYPE): state_d = ST_W'(S_EXR);
                    OP_W'(OP_ADDI):  state_d = ST_W'(S_EXI);
                    OP_W'(OP_BEQ):   state_d = ST_W'(S_BR);
                    OP_W'(OP_J):     state_d = ST_W'(S_JMP);
`ifdef MCCPU_ILLEGAL_TRAP_EN
                    default:         state_d = ST_W'(S_TRAP);
`else
                    default:         state_d = ST_W'(S_IF);
`endif
                endcase
            end
            ST_W'(S_MADDR): state_d = (OpCode == OP_W'(OP_LW)) ? ST_W'(S_MRD)
                                                              : ST_W'(S_MWR);
            ST_W'(S_MRD):   state_d = ST_W'(S_WBL);
            ST_W'(S_EXR):   state_d = ST_W'(S_WBR);
            ST_W'(S_EXI):   state_d = ST_W'(S_WBI);
            // final states, TRAP and unused encodings all return to fetch
            default:        state_d = ST_W'(S_IF);
        endcase
    end

    // State register with synchronous reset; reset aborts any instruction
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_W'(S_IF);
        else       state_q <= state_d;
    end

`ifdef MCCPU_ILLEGAL_TRAP_EN
    logic exc_trap_raw;
`endif

    mccpu_ctrl_decode #(.ST_W(ST_W)) u_decode (
        .state_i    (state_q),
`ifdef MCCPU_ILLEGAL_TRAP_EN
        .exc_trap_o (exc_trap_raw),
`endif
        .ctrl_o     (ctrl_raw)
    );

    // Squash every enable while reset is high so nothing writes during reset
    always_comb begin
        ctrl = reset ? '0 : ctrl_raw;
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
`ifdef MCCPU_ILLEGAL_TRAP_EN
    assign ExcTrap     = exc_trap_raw & ~reset;
`endif
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level reference model (state
// sequence per opcode, per-state output rules) checked every cycle, plus
// directed literal checks. Honours MCCPU_ILLEGAL_TRAP_EN like the RTL.
module tb_multicycle_ctrl_fsm;

`ifdef MCCPU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = 6'h2B;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       ExcTrap;
    logic [3:0] State;

    multicycle_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
`ifdef MCCPU_ILLEGAL_TRAP_EN
        .ExcTrap     (ExcTrap),
`endif
        .State       (State)
    );
`ifndef MCCPU_ILLEGAL_TRAP_EN
    assign ExcTrap = 1'b0;
`endif

    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  exp_valid = 1'b0;
    bit  exp_rst = 1'b0;
    int  exp_state = 0;

    // Instruction-level model: the state numbers visited for one opcode
    function automatic int model_seq(input logic [5:0] op, output int s[6]);
        s = '{0, 1, 0, 0, 0, 0};
        case (op)
            6'h23: begin s[2] = 2;  s[3] = 3; s[4] = 4; return 5; end
            6'h2B: begin s[2] = 2;  s[3] = 5; return 4; end
            6'h00: begin s[2] = 6;  s[3] = 7; return 4; end
            6'h08: begin s[2] = 10; s[3] = 11; return 4; end
            6'h04: begin s[2] = 8;  return 3; end
            6'h02: begin s[2] = 9;  return 3; end
            default: begin
                if (TRAP_EN) begin s[2] = 12; return 3; end
                return 2;
            end
        endcase
    endfunction

    // Per-state output rules, packed in the same order as dut_ctrl below
    function automatic logic [16:0] model_ctrl(input int s, input bit rst);
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       trap;
        if (rst) return '0;
        pcw  = (s == 0) || (s == 9) || (s == 12);
        pcwc = (s == 8);
        iord = (s == 3) || (s == 5);
        mrd  = (s == 0) || (s == 3);
        mwr  = (s == 5);
        irw  = (s == 0);
        m2r  = (s == 4);
        rdst = (s == 7);
        rw   = (s == 4) || (s == 7) || (s == 11);
        asa  = (s == 2) || (s == 6) || (s == 8) || (s == 10);
        asb  = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s == 2 || s == 10) ? 2'd2 : 2'd0;
        aop  = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
        psrc = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : (s == 12) ? 2'd3 : 2'd0;
        trap = (s == 12);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, trap};
    endfunction

    wire [16:0] dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                            PCSource, ExcTrap};

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) begin
            n_vec++;
            if (State !== 4'(exp_state)) begin
                n_bad++;
                $display("FAIL state @%0t: got %0d want %0d", $time, State, exp_state);
            end
            n_vec++;
            if (dut_ctrl !== model_ctrl(exp_state, exp_rst)) begin
                n_bad++;
                $display("FAIL ctrl(state %0d rst %0d) @%0t: got %b want %b",
                         exp_state, exp_rst, $time, dut_ctrl, model_ctrl(exp_state, exp_rst));
            end
        end
    end

    // One clock: inputs and expected state for the cycle after this edge
    task automatic cycle(input bit rst, input logic [5:0] op, input int st);
        @(posedge clk);
        #1;
        reset     = rst;
        OpCode    = op;
        exp_rst   = rst;
        exp_state = st;
        exp_valid = 1'b1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_instr(input logic [5:0] op);
        int s[6];
        int n;
        n = model_seq(op, s);
        for (int i = 0; i < n; i++) cycle(1'b0, op, s[i]);
    endtask

    initial begin
        int s[6];
        int n, k;
        logic [5:0] op;
        logic [5:0] legal [6];
        legal = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};

        // 1: reset held two cycles with sw opcode present
        @(posedge clk);
        #1;
        cycle(1'b1, 6'h2B, 0);
        cycle(1'b1, 6'h2B, 0);
        @(negedge clk);
        lit("reset_state", 32'(State), 32'd0);
        lit("reset_memread", 32'(MemRead), 32'd0);
        lit("reset_pcwrite", 32'(PCWrite), 32'd0);
        cycle(1'b0, 6'h2B, 0);
        @(negedge clk);
        lit("fetch_after_reset", 32'({MemRead, IRWrite, PCWrite, ALUSrcB}), 32'b11101);
        cycle(1'b0, 6'h2B, 1);
        cycle(1'b0, 6'h2B, 2);
        cycle(1'b0, 6'h2B, 5);

        // 2: lw
        cycle(1'b0, 6'h23, 0);
        cycle(1'b0, 6'h23, 1);
        cycle(1'b0, 6'h23, 2);
        cycle(1'b0, 6'h23, 3);
        @(negedge clk);
        lit("lw_mrd", 32'({MemRead, IorD}), 32'b11);
        cycle(1'b0, 6'h23, 4);
        @(negedge clk);
        lit("lw_wbl", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);

        // 3: R-type, addi
        run_instr(6'h00);
        run_instr(6'h08);

        // 4: beq, j
        cycle(1'b0, 6'h04, 0);
        cycle(1'b0, 6'h04, 1);
        cycle(1'b0, 6'h04, 8);
        @(negedge clk);
        lit("beq_br", 32'({PCWriteCond, PCWrite, PCSource}), 32'b1001);
        cycle(1'b0, 6'h02, 0);
        cycle(1'b0, 6'h02, 1);
        cycle(1'b0, 6'h02, 9);
        @(negedge clk);
        lit("j_jmp", 32'({PCWrite, PCSource}), 32'b110);

        // 5: reset during lw MRD
        cycle(1'b0, 6'h23, 0);
        cycle(1'b0, 6'h23, 1);
        cycle(1'b0, 6'h23, 2);
        cycle(1'b1, 6'h23, 3);
        @(negedge clk);
        lit("rst_in_mrd_memread", 32'(MemRead), 32'd0);
        cycle(1'b1, 6'h23, 0);
        @(negedge clk);
        lit("rst_abort_state", 32'(State), 32'd0);
        run_instr(6'h2B);

        // 6: undefined opcode
        run_instr(6'h3F);
        cycle(1'b0, 6'h3F, 0);
        @(negedge clk);
        lit("after_illegal_state", 32'(State), 32'd0);
        cycle(1'b0, 6'h3F, 1);
        if (TRAP_EN) begin
            cycle(1'b0, 6'h3F, 12);
            @(negedge clk);
            lit("trap", 32'({ExcTrap, PCWrite, PCSource}), 32'b1111);
        end

        // Randomized instruction stream with occasional mid-instruction reset
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal[$urandom_range(0, 5)];
            n = model_seq(op, s);
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, n - 1);
                for (int i = 0; i < k; i++) cycle(1'b0, op, s[i]);
                cycle(1'b1, op, s[k]);
                for (int r = $urandom_range(1, 2); r > 0; r--) cycle(1'b1, op, 0);
            end else begin
                for (int i = 0; i < n; i++) cycle(1'b0, op, s[i]);
            end
        end

        cycle(1'b0, 6'h00, 0);
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine of the multi-cycle MIPS CPU. It sits directly downstream of the instruction register and consumes its registered OpCode.
- It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable, including IRWrite back to the instruction register.
- Moore machine: outputs are decoded from the current state only.

Parameters:
- OP_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on the clk rising edge only
- OpCode  in  OP_W  registered opcode from the instruction register; valid from state ID onward
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero (beq)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select: 1=MDR
- RegDst  out  1  destination select: 1=rd, 0=rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A register
- ALUSrcB  out  2  ALU B select: 00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=use Funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector
- State  out  ST_W  current state, for debug

Behaviour:
- State encodings:
  - IF=0, ID=1, MADDR=2, MRD=3, WBL=4, MWR=5
  - EXR=6, WBR=7, BR=8, JMP=9, EXI=10, WBI=11, TRAP=12
- Reset:
  - reset high at a clk edge sets state to IF.
  - While reset is high, all outputs except State are forced to 0, so no memory or register writes occur during reset.
  - Reset asserted mid-instruction aborts the instruction; the next state is IF.
- Transitions (all one cycle per state):
  - IF -> ID.
  - ID decodes OpCode: 0x23 (lw) or 0x2B (sw) -> MADDR; 0x00 -> EXR; 0x08 (addi) -> EXI; 0x04 (beq) -> BR; 0x02 (j) -> JMP; any other opcode -> see Optional Feature.
  - MADDR: lw -> MRD, sw -> MWR.
  - MRD -> WBL. EXR -> WBR. EXI -> WBI.
  - WBL, MWR, WBR, WBI, BR, JMP, TRAP -> IF.
  - Encodings 13-15 -> IF.
- Instruction latency:
  - lw = 5 cycles.
  - sw, R-type, addi = 4 cycles.
  - beq, j = 3 cycles.
- Asserted outputs per state (all outputs not listed are 0):
  - IF: MemRead, IRWrite, PCWrite, ALUSrcB=01.
  - ID: ALUSrcB=11 (precompute branch target).
  - MADDR, EXI: ALUSrcA=1, ALUSrcB=10.
  - MRD: MemRead, IorD.
  - MWR: MemWrite, IorD.
  - WBL: RegWrite, MemtoReg.
  - EXR: ALUSrcA=1, ALUOp=10.
  - WBR: RegWrite, RegDst.
  - WBI: RegWrite.
  - BR: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01.
  - JMP: PCWrite, PCSource=10.
- IRWrite is high only in IF, so OpCode stays stable from ID until the next IF.
- Outputs are purely combinational from state; no output depends on OpCode directly, so there are no glitch paths through the instruction register.

Optional Feature:
- Macro: MCCPU_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in ID goes to TRAP.
  - TRAP asserts PCWrite, PCSource=11 and the extra output port ExcTrap=1 for one cycle, then goes to IF.
- Undefined:
  - An undefined opcode in ID goes straight to IF and is executed as a NOP.
  - State 12 is unreachable.
  - The ExcTrap port is absent.

Decomposition:
- Shared package mccpu_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUSrcB, ALUOp and PCSource code constants, so the datapath muxes and this block share one definition
- One sub-module is natural: mccpu_ctrl_decode, the combinational state-to-control-word decoder. The top level keeps the state register and next-state logic.

Test Plan:
1. Hold reset for 2 cycles with OpCode=0x2B -> all control outputs 0 and State=0 during reset. First cycle after release: State=0, MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
2. OpCode=0x23 -> State sequence 0,1,2,3,4,0. MRD has MemRead=IorD=1. WBL has RegWrite=MemtoReg=1, RegDst=0.
3. OpCode=0x00, then 0x08 -> sequences 0,1,6,7,0 and 0,1,10,11,0. RegDst=1 only in state 7. ALUOp=10 only in state 6.
4. OpCode=0x04, then 0x02 -> sequences 0,1,8,0 and 0,1,9,0. State 8: PCWriteCond=1, PCWrite=0, PCSource=01. State 9: PCWrite=1, PCSource=10.
5. Assert reset while State=3 (lw MRD) -> next cycle State=0 and MemRead=0 while reset is held. Normal fetch resumes after release.
6. OpCode=0x3F -> with MCCPU_ILLEGAL_TRAP_EN: 0,1,12,0, and state 12 shows ExcTrap=1, PCSource=11, PCWrite=1. Without the macro: 0,1,0.
